axis_byte_packer: RTL

//  Packs the 8-bit AXIS byte stream from ft245_sync_to_axis (m_axis side, BUS_WIDTH=1) into
//  OUT_BYTES-wide little-endian words for downstream wide-bus logic (DMA/FIFO).

---
 rtl/axis_byte_packer_if.sv | 18 +
 rtl/axis_byte_packer.sv | 102 ++++++++++
 2 files changed

// File: rtl/axis_byte_packer_if.sv
// AXI-Stream bus bundle used on both sides of the byte packer.
//   BYTES   bus width in bytes; tdata is 8*BYTES bits, tkeep is BYTES bits
//   tdata   payload, byte k in [8k+7:8k]
//   tkeep   per-byte valid mask
//   tvalid  source has a beat
//   tready  sink can take the beat
// Modports: master drives tdata/tkeep/tvalid and samples tready; slave is the mirror.
interface axis_byte_packer_if #(
    parameter int BYTES = 1
);
    logic [8*BYTES-1:0] tdata;
    logic [BYTES-1:0]   tkeep;
    logic               tvalid;
    logic               tready;

    modport master (output tdata, output tkeep, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, output tready);
endinterface

// File: rtl/axis_byte_packer.sv
// Packs an 8-bit AXI-Stream byte stream into OUT_BYTES-wide little-endian words.
// A partial word is flushed after TIMEOUT idle cycles, with tkeep marking the
// filled lanes (always contiguous from lane 0). TIMEOUT=0 disables flushing.
// Ports:
//   aclk    clock, rising edge
//   arst    synchronous reset, active high
//   s_axis  byte input  (slave,  BYTES=1); a beat with tkeep=0 is consumed and dropped
//   m_axis  word output (master, BYTES=OUT_BYTES); byte k of the word in [8k+7:8k]
module axis_byte_packer #(
    parameter int OUT_BYTES = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic               aclk,
    input  logic               arst,
    axis_byte_packer_if.slave  s_axis,
    axis_byte_packer_if.master m_axis
);
    localparam int              CW       = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
    localparam int              IW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   LAST     = CW'(OUT_BYTES - 1);
    localparam logic [IW-1:0]   IDLE_MAX = IW'(TIMEOUT);
    localparam bit              FLUSH_EN = (TIMEOUT != 0);

    logic [OUT_BYTES-1:0][7:0] acc;
    logic [OUT_BYTES-1:0][7:0] full_word;
    logic [OUT_BYTES-1:0][7:0] out_data;
    logic [OUT_BYTES-1:0]      part_keep;
    logic [OUT_BYTES-1:0]      out_keep;
    logic                      out_valid;
    logic [CW-1:0]             cnt;
    logic [IW-1:0]             idle;

    logic out_free;
    logic s_ready;
    logic accept;
    logic complete;
    logic flush;

    always_comb begin
        out_free  = ~out_valid | m_axis.tready;
        // Only the word-completing byte needs the output register, so stall just that one.
        s_ready   = (cnt != LAST) | out_free;
        accept    = s_axis.tvalid & s_ready & s_axis.tkeep[0];
        complete  = accept & (cnt == LAST);
        // An accept on the due cycle cancels the flush; the byte is appended instead.
        flush     = FLUSH_EN & (cnt != '0) & (idle == IDLE_MAX) & ~accept & out_free;

        full_word       = acc;
        full_word[LAST] = s_axis.tdata;

        part_keep = '0;
        for (int k = 0; k < OUT_BYTES; k++) begin
            part_keep[k] = (k < int'(cnt));
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            acc       <= '0;
            cnt       <= '0;
            idle      <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else if (complete) begin
            // Load may coincide with the downstream handshake: tvalid simply stays high.
            out_data  <= full_word;
            out_keep  <= '1;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            idle      <= '0;
        end else if (flush) begin
            // acc lanes at and above cnt are still zero from the last clear.
            out_data  <= acc;
            out_keep  <= part_keep;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            idle      <= '0;
        end else begin
            if (m_axis.tready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                acc[cnt] <= s_axis.tdata;
                cnt      <= cnt + 1'b1;
                idle     <= '0;
            end else if (cnt == '0) begin
                idle <= '0;
            end else if (idle != IDLE_MAX) begin
                // Saturate so a flush blocked by backpressure stays pending.
                idle <= idle + 1'b1;
            end
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = out_data;
    assign m_axis.tkeep  = out_keep;
    assign m_axis.tvalid = out_valid;
endmodule
